lfsr_gen: RTL
=============

Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR and the successor to the fixed 16/64-bit generators.
- Adds configurable width and tap mask, XOR/XNOR feedback, synchronous seed load, a free-run enable, a counted-burst advance with req/done handshake, and lock-up detection with optional recovery.
- Feeds pseudo-random values to game/test logic that needs either a new value per cycle or exactly N steps on demand.

Parameters:
- WIDTH, 16, register width (>= 3).
- TAPS, 16'hD008, feedback mask; bit i set = state[i] participates (default = bits 15,14,12,3).
- XNOR, 1, 1 = inverted-parity feedback, 0 = XOR feedback.
- STEP_W, 8, width of burst step count.
- RESET_VAL, 0, value of state after reset.
- RECOVER, 1, 1 = escape lock-up state on the next advance, 0 = hold in lock-up.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- seed  in  WIDTH  value loaded on load.
- load  in  1  synchronous seed load, highest priority.
- en  in  1  free-run: one shift per cycle while high and idle.
- req  in  1  burst request, sampled only in IDLE.
- step_cnt  in  STEP_W  number of shifts for the burst.
- state  out  WIDTH  current LFSR value (registered).
- busy  out  1  high while in BURST.
- done  out  1  one-cycle pulse when a burst completes.
- lockup  out  1  high while state equals LOCK.

Behaviour:
- Reset (reset_n low, asynchronous): state = RESET_VAL, FSM = IDLE, remaining = 0, busy = 0, done = 0. lockup is combinational from state.
- Shift: next = {state[WIDTH-2:0], fb}.
  - p = XOR-reduce(state & TAPS).
  - fb = ~p if XNOR = 1, else fb = p.
- LOCK = all ones when XNOR = 1, all zeros when XNOR = 0. lockup = (state == LOCK).
- Advance in lock-up:
  - RECOVER = 1: state becomes LOCK with bit 0 inverted, instead of the shift.
  - RECOVER = 0: normal shift, so state stays LOCK.
- FSM states: IDLE, BURST.
- IDLE, per edge, in priority order:
  1. load: state = seed; req and en are ignored this cycle.
  2. req with step_cnt = 0: no shift; done = 1 the next cycle; stay IDLE.
  3. req with step_cnt > 0: remaining = step_cnt; go to BURST; no shift on the accept edge.
  4. en: one advance.
  5. Otherwise: hold.
- BURST, per edge:
  - load: state = seed, go to IDLE, remaining = 0, no done (abort).
  - Otherwise: one advance and remaining decrements. When remaining was 1, go to IDLE and set done = 1 for exactly one cycle.
  - en and req are ignored in BURST.
- Latency: req accepted at edge k with count N gives shifts at edges k+1 .. k+N. done and busy = 0 are both visible after edge k+N. busy is high from edge k+1 to edge k+N.
- Back-to-back: req held high in the done cycle is accepted; a new burst starts immediately.
- Reset mid-burst: immediate return to the reset state; done is not generated.
- Width rules: step_cnt is unsigned. Maximum burst = 2^STEP_W - 1 shifts.

Test Plan:
- Reset with defaults -> state = 0x0000, busy = 0, done = 0, lockup = 0; reassert reset_n low mid-burst -> state back to 0x0000, no done.
- load seed = 0x0001, en = 1 for 4 cycles -> state sequence 0x0003, 0x0007, 0x000F, 0x001E.
- load 0x0001, req with step_cnt = 4 -> busy high 4 cycles, state 0x001E when done pulses (single cycle); step_cnt = 0 -> done next cycle, state unchanged, busy never high.
- During a step_cnt = 10 burst, assert load with seed = 0xACE1 at the 3rd busy cycle -> state = 0xACE1, busy = 0, no done; en high during a burst -> exactly 10 shifts total.
- load 0xFFFF (XNOR) -> lockup = 1; en one cycle -> state 0xFFFE, lockup = 0. With RECOVER = 0 -> state stays 0xFFFF, lockup stays 1.
- WIDTH = 8, TAPS = 8'hB8, XNOR = 0, seed 0x01, free-run 255 cycles -> returns to 0x01 with no repeat earlier and 0x00 never reached; load 0x00 -> lockup = 1, first advance gives 0x01.

Source files
------------

// File: rtl/lfsr_gen_if.sv
// Control/data bundle between an LFSR consumer and lfsr_gen.
// The consumer drives the seed/advance requests and observes the state and burst status.
interface lfsr_gen_if #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 8
);
  logic [WIDTH-1:0]  seed;
  logic              load;
  logic              en;
  logic              req;
  logic [STEP_W-1:0] step_cnt;
  logic [WIDTH-1:0]  state;
  logic              busy;
  logic              done;
  logic              lockup;

  modport master (
    output seed, load, en, req, step_cnt,
    input  state, busy, done, lockup
  );

  modport slave (
    input  seed, load, en, req, step_cnt,
    output state, busy, done, lockup
  );
endinterface

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with seed load, free-run enable and counted bursts (req/done).
// Burst of N shifts accepted at edge k shifts on edges k+1..k+N; done pulses after edge k+N.
module lfsr_gen #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(16'hD008),
  parameter bit               XNOR      = 1'b1,
  parameter int               STEP_W    = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               RECOVER   = 1'b1
) (
  input  logic     clk,
  input  logic     reset_n,
  lfsr_gen_if.slave bus
);

  typedef enum logic {IDLE, BURST} fsm_e;

  // The one value the feedback can never leave on its own.
  localparam logic [WIDTH-1:0] LOCK = {WIDTH{XNOR}};

  fsm_e              fsm_q, fsm_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  adv;

  always_comb begin
    adv = {lfsr_q[WIDTH-2:0], (^(lfsr_q & TAPS)) ^ XNOR};
    if (RECOVER && (lfsr_q == LOCK)) begin
      adv = LOCK ^ WIDTH'(1);
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    lfsr_d = lfsr_q;
    rem_d  = rem_q;
    done_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (bus.load) begin
          lfsr_d = bus.seed;
        end else if (bus.req) begin
          if (bus.step_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d = bus.step_cnt;
            fsm_d = BURST;
          end
        end else if (bus.en) begin
          lfsr_d = adv;
        end
      end
      BURST: begin
        // A load aborts the burst silently: no done pulse.
        if (bus.load) begin
          lfsr_d = bus.seed;
          rem_d  = '0;
          fsm_d  = IDLE;
        end else begin
          lfsr_d = adv;
          rem_d  = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q  <= IDLE;
      lfsr_q <= RESET_VAL;
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      lfsr_q <= lfsr_d;
      rem_q  <= rem_d;
      done_q <= done_d;
    end
  end

  assign bus.state  = lfsr_q;
  assign bus.busy   = (fsm_q == BURST);
  assign bus.done   = done_q;
  assign bus.lockup = (lfsr_q == LOCK);

endmodule
